// File: rtl/serial_tx_buffer.sv
// Byte FIFO feeding a UART transmitter (8N1, or 8E1 with SERIAL_TX_PARITY_EN).
// Frames run back to back while the FIFO holds data; overflow is sticky.
module serial_tx_buffer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            data_in,
    input  logic                  wren_in,
    output logic                  ready_out,
    output logic                  tx_out,
    output logic                  busy_out,
    output logic                  overflow_out,
    output logic [DEPTH_LOG2:0]   count_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q;
    logic                  push, pop, bit_end;

    assign ready_out    = (count_q != FULL);
    assign push         = wren_in && ready_out;
    assign bit_end      = (cnt_q == BIT_LAST);
    assign tx_out       = tx_q;
    assign busy_out     = (state_q != IDLE);
    assign overflow_out = ovf_q;
    assign count_out    = count_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shreg_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shreg_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // chain straight into the next start bit, no idle gap
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wren_in && !ready_out) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Randomised bench for serial_tx_buffer against a queue-and-frame model.
// Define SERIAL_TX_PARITY_EN for both DUT and bench to check 8E1 frames.
module tb_serial_tx_buffer;

    localparam int CPB   = 4;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FR   = NBITS * CPB;
    localparam int LOGN = 8192;

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     data_in;
    logic           wren_in;
    logic           ready_out;
    logic           tx_out;
    logic           busy_out;
    logic           overflow_out;
    logic [DL2:0]   count_out;

    serial_tx_buffer #(
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2(DL2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .wren_in(wren_in),
        .ready_out(ready_out),
        .tx_out(tx_out),
        .busy_out(busy_out),
        .overflow_out(overflow_out),
        .count_out(count_out)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [7:0]  q [$];
    bit          m_active;
    bit          m_ovf;
    int          m_pos;
    logic [10:0] m_bits;
    logic        txlog [LOGN];
    logic        busylog [LOGN];

    // whole line image of one frame: start, data LSB first, parity, stop
    function automatic logic [10:0] frame_of(logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step(logic r, logic w, logic [7:0] d);
        bit rdy;
        reset   = r;
        wren_in = w;
        data_in = d;
        @(posedge clock);
        cyc++;
        rdy = (q.size() < DEPTH);
        if (r) begin
            q.delete();
            m_active = 0;
            m_ovf    = 0;
            m_pos    = 0;
        end else begin
            if (m_active && m_pos < FR - 1) begin
                m_pos++;
            end else begin
                m_active = 0;
                if (q.size() > 0) begin
                    m_bits   = frame_of(q.pop_front());
                    m_active = 1;
                    m_pos    = 0;
                end
            end
            if (w) begin
                if (rdy) q.push_back(d);
                else m_ovf = 1;
            end
        end
        #1;
        if (cyc < LOGN) begin
            txlog[cyc]   = tx_out;
            busylog[cyc] = busy_out;
        end
        check("tx", tx_out, m_active ? int'(m_bits[m_pos / CPB]) : 1);
        check("busy", busy_out, m_active);
        check("count", count_out, q.size());
        check("ready", ready_out, q.size() < DEPTH);
        check("overflow", overflow_out, m_ovf);
    endtask

    initial begin
        int         n0, t, nf, run, maxrun, dens, nbusy;
        logic [7:0] pat, b;
        logic [7:0] sent [18];

        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        check("rst_tx", tx_out, 1);
        check("rst_ready", ready_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_count", count_out, 0);

        // single 0x55 frame, pinned cycle by cycle
        step(0, 0, 8'h00);
        step(0, 1, 8'h55);
        n0 = cyc;
        repeat (FR + 8) step(0, 0, 8'h00);
        pat = 8'h55;
        check("idle_before", txlog[n0], 1);
        for (int k = 1; k <= 4; k++) check("start_bit", txlog[n0 + k], 0);
        for (int bi = 0; bi < 8; bi++)
            for (int c = 0; c < 4; c++)
                check("data_bit", txlog[n0 + 5 + 4 * bi + c], pat[bi]);
`ifdef SERIAL_TX_PARITY_EN
        check("parity_55", txlog[n0 + 38], 0);
`endif
        check("stop_bit", txlog[n0 + FR], 1);
        check("busy_last", busylog[n0 + FR], 1);
        check("busy_fall", busylog[n0 + FR + 1], 0);

        // back-to-back frames
        step(0, 1, 8'h41);
        n0 = cyc;
        step(0, 1, 8'h42);
        repeat (2 * FR + 10) step(0, 0, 8'h00);
        check("b2b_stop", txlog[n0 + FR], 1);
        check("b2b_start", txlog[n0 + FR + 1], 0);
        run = 0;
        maxrun = 0;
        for (int k = n0 + 1; k <= n0 + 2 * FR; k++) begin
            run = txlog[k] ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("b2b_max_high", maxrun, 4);
`ifdef SERIAL_TX_PARITY_EN
        pat = 8'h07;
        check("parity_07", frame_of(pat) >> 9 & 1, 1);
        pat = 8'h03;
        check("parity_03", frame_of(pat) >> 9 & 1, 0);
`endif

        // 18 pushes from idle: the 18th bounces
        step(1, 0, 8'h00);
        for (int i = 0; i < 18; i++) begin
            sent[i] = 8'($urandom);
            step(0, 1, sent[i]);
            if (i == 0) n0 = cyc;
            if (i == 16) begin
                check("full_count", count_out, 16);
                check("full_ready", ready_out, 0);
                check("full_ovf", overflow_out, 0);
            end
        end
        check("rej_count", count_out, 16);
        check("rej_ovf", overflow_out, 1);
        repeat (17 * FR + 20) step(0, 0, 8'h00);
        check("ovf_sticky", overflow_out, 1);
        t = n0 + 1;
        nf = 0;
        while (t < cyc - FR && nf < 20) begin
            if (txlog[t] == 1'b0) begin
                for (int bi = 0; bi < 8; bi++)
                    b[bi] = txlog[t + CPB * (bi + 1) + CPB / 2];
                if (nf < 17) check("rx_byte", b, sent[nf]);
                nf++;
                t += FR;
            end else begin
                t++;
            end
        end
        check("rx_frames", nf, 17);

        // push while full in the same cycle as the end-of-stop pop
        step(1, 0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 8'($urandom));
            if (i == 0) n0 = cyc;
        end
        while (cyc < n0 + FR) step(0, 0, 8'h00);
        check("pre_pop_count", count_out, 16);
        step(0, 1, 8'hAA);
        check("pop_rej_count", count_out, 15);
        check("pop_rej_ovf", overflow_out, 1);

        // reset during data bit 3, with a push in the reset cycle
        step(1, 0, 8'h00);
        step(0, 1, 8'hA5);
        n0 = cyc;
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
        while (cyc < n0 + 17) step(0, 0, 8'h00);
        check("mid_busy", busy_out, 1);
        step(1, 1, 8'h33);
        check("abort_tx", tx_out, 1);
        check("abort_busy", busy_out, 0);
        check("abort_count", count_out, 0);
        check("abort_ovf", overflow_out, 0);
        nbusy = 0;
        repeat (60) begin
            step(0, 0, 8'h00);
            if (busy_out) nbusy++;
        end
        check("abort_no_frames", nbusy, 0);

        // random traffic with shifting write density and rare resets
        step(1, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dens = $urandom_range(2, 95);
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 99) < dens),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_tx_buffer.md
SERIAL_TX_BUFFER -- requirements
Module: serial_tx_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit period (legal range 2..65535).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, so that FIFO depth is DEPTH = 2^DEPTH_LOG2 bytes.
REQ-003 SHALL have port clock, input, 1, the single clock; every flop is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port data_in, input, 8, the byte from the processor serial_out.
REQ-006 SHALL have port wren_in, input, 1, a write strobe from the processor serial_wren_out.
REQ-007 SHALL have port ready_out, output, 1, space available; it drives the processor serial_ready_in.
REQ-008 SHALL have port tx_out, output, 1, the UART line: 8N1, or 8E1 when parity is enabled.
REQ-009 SHALL have port busy_out, output, 1, high while a frame is being transmitted.
REQ-010 SHALL have port overflow_out, output, 1, a sticky flag for a rejected write.
REQ-011 SHALL have port count_out, output, DEPTH_LOG2+1, the current FIFO occupancy.

Function
REQ-012 SHALL define the FIFO as DEPTH x 8 bits with read and write pointers that wrap modulo DEPTH and a registered count in the range 0..DEPTH.
REQ-013 SHALL drive ready_out = (count < DEPTH) from registered state only.
REQ-014 SHALL accept a push at a rising edge when wren_in=1 and ready_out=1; data_in is stored at the write pointer.
REQ-015 SHALL reject a push when wren_in=1 and ready_out=0, even if a pop occurs in the same cycle; the FIFO is unchanged and overflow_out is set to 1 until reset.
REQ-016 SHALL leave count unchanged on a simultaneous push and pop, and write and read pointers each advance by one.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA, PARITY (present only when compiled in) and STOP, with a bit-period counter and a 3-bit bit index.
REQ-018 SHALL, in IDLE, hold tx_out=1 and, if count>0, pop the head byte into a shift register, clear the bit-period counter, and enter START at that same edge.
REQ-019 SHALL hold START, DATA, PARITY and STOP for exactly CLKS_PER_BIT cycles per bit each.
REQ-020 SHALL drive tx_out as follows: START 0; DATA shift-register bits LSB first for 8 bit periods; PARITY even-parity bit; STOP 1.
REQ-021 SHALL, at the end of STOP, pop the next byte and enter START directly if count>0 (no idle gap), and otherwise enter IDLE.
REQ-022 SHALL, for a byte pushed into an empty FIFO while IDLE at edge N, pop it at edge N+1 and drive tx_out low from edge N+1.
REQ-023 SHALL register tx_out, with no combinational path from any input to it.
REQ-024 SHALL assert busy_out whenever the state is not IDLE.
REQ-025 SHALL give a frame length of 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, set tx_out=1, ready_out=1, busy_out=0, overflow_out=0, count_out=0, pointers to 0, and state to IDLE.
REQ-027 SHALL, when reset is asserted mid-frame, abort the frame (tx_out=1 after that edge) and discard all FIFO contents; a push in that same cycle is ignored.

Configuration
REQ-028 SHALL compile in the PARITY state and the even-parity bit when SERIAL_TX_PARITY_EN is defined, with tx_out in PARITY equal to the XOR of the 8 data bits.
REQ-029 SHALL, when SERIAL_TX_PARITY_EN is undefined, omit the PARITY state so that DATA goes directly to STOP and frames are 8N1.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=4)
REQ-030 SHALL verify: push 0x55 while idle at edge N -> tx_out=0 over cycles N+1..N+4, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1; busy_out falls at N+41 (N+45 with parity).
REQ-031 SHALL verify: pushes 0x41 then 0x42 on consecutive edges -> second start bit immediately follows the first stop period; tx_out is never high for more than 4 cycles between frames.
REQ-032 SHALL verify: 18 consecutive pushes from idle -> count_out reaches 16 and ready_out=0 after the 17th, the 18th is rejected, and overflow_out=1 and stays high; transmitted bytes equal the first 17 in order.
REQ-033 SHALL verify: reset asserted during DATA bit 3 -> the next edge gives tx_out=1, busy_out=0, count_out=0, overflow_out=0, with no further frames.
REQ-034 SHALL verify: with SERIAL_TX_PARITY_EN defined, push 0x07 -> parity bit=1; push 0x03 -> parity bit=0.
REQ-035 SHALL verify: push while full with a simultaneous pop at the end of STOP -> push rejected, count_out decrements by 1, overflow_out=1.
